// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: request kinds, access sizes,
// FSM states and the latched request record.
package mem_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        STORE = 2'b01,
        FETCH = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        kind_e       kind;
        size_e       size;
        logic        sign;
        logic [31:0] ea;
        logic [31:0] wdata;
    } req_t;

    // The reserved code 2'b10 behaves as a load.
    function automatic kind_e decode_kind(input logic [1:0] w_r);
        case (w_r)
            2'b11:   return FETCH;
            2'b01:   return STORE;
            default: return LOAD;
        endcase
    endfunction

    // Size code 2'b11 behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] wordsize);
        case (wordsize)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Single-channel valid/ready memory bus between the access unit (master)
// and the memory or interconnect (slave).
interface mem_interface_if;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_lane.sv
// Byte-lane steering: store strobes and replication, load alignment and
// extension, and the alignment rule for each access size.
module mem_lane
    import mem_pkg::*;
(
    input  logic [1:0]  ea_lo,
    input  size_e       size,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a value before the case so that no path through it can infer a latch.
        shifted    = raw_rdata >> {ea_lo, 3'b000};
        wstrb      = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = shifted;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                wstrb     = 4'b0001 << ea_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                wstrb      = 4'b0011 << ea_lo;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign & shifted[15]}}, shifted[15:0]};
                misaligned = ea_lo[0];
            end
            default: begin
                misaligned = |ea_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_interface.sv
// Memory access unit: takes one fetch/load/store request from the control FSM
// and runs it as a single transaction on the valid/ready bus.
module mem_interface
    import mem_pkg::*;
#(
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_mem,
    input  logic [1:0]         W_R_mem,
    input  logic [1:0]         wordsize_mem,
    input  logic               sign_mem,
    input  logic [31:0]        pc,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               busy_mem,
    output logic               done_mem,
    output logic               aligned_mem,
    output logic               bus_err,
    output logic [31:0]        inst,
    output logic [31:0]        rdata,
    mem_interface_if.master    bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_e           state_q, state_d;
    req_t             req_in, req_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_idle, in_req;
    logic             accept, handshake, timed_out;
    logic [1:0]       lane_ea;
    size_e            lane_size;
    logic [3:0]       lane_wstrb;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_rdata;
    logic             misaligned;

    always_comb begin
        req_in.kind  = decode_kind(W_R_mem);
        req_in.size  = (req_in.kind == FETCH) ? WORD : decode_size(wordsize_mem);
        req_in.sign  = sign_mem;
        req_in.ea    = (req_in.kind == FETCH) ? pc : addr;
        req_in.wdata = wdata;
    end

    assign in_idle   = (state_q == IDLE);
    assign in_req    = (state_q == REQ);
    assign accept    = in_idle && en_mem;
    assign handshake = in_req && bus.mem_ready;
    assign timed_out = in_req && !bus.mem_ready && (TIMEOUT != 0)
                       && (int'(tmo_cnt) == TIMEOUT - 1);

    // In IDLE the lane judges the incoming request's alignment; afterwards it
    // steers the latched request.
    assign lane_ea   = in_idle ? req_in.ea[1:0] : req_q.ea[1:0];
    assign lane_size = in_idle ? req_in.size    : req_q.size;

    mem_lane u_lane (
        .ea_lo      (lane_ea),
        .size       (lane_size),
        .sign       (req_q.sign),
        .wdata      (req_q.wdata),
        .raw_rdata  (bus.mem_rdata),
        .wstrb      (lane_wstrb),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (lane_rdata),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !misaligned)   state_d = REQ;
            REQ:     if (handshake || timed_out)  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_mem = !in_idle;
    assign done_mem = (state_q == RESP);

    // Bus outputs derive from state so a reset drops the request at once.
    assign bus.mem_valid = in_req;
    assign bus.mem_instr = in_req && (req_q.kind == FETCH);
    assign bus.mem_addr  = in_req ? {req_q.ea[31:2], 2'b00} : 32'h0;
    assign bus.mem_wstrb = (in_req && req_q.kind == STORE) ? lane_wstrb : 4'b0000;
    assign bus.mem_wdata = (in_req && req_q.kind == STORE) ? lane_wdata : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            aligned_mem <= 1'b1;
            bus_err     <= 1'b0;
            inst        <= RESET_INST;
            rdata       <= 32'h0;
            tmo_cnt     <= '0;
        end else begin
            if (accept) begin
                req_q       <= req_in;
                aligned_mem <= !misaligned;
                bus_err     <= 1'b0;
                tmo_cnt     <= '0;
            end
            if (in_req) begin
                if (handshake) begin
                    if (req_q.kind == FETCH)     inst  <= bus.mem_rdata;
                    else if (req_q.kind == LOAD) rdata <= lane_rdata;
                end else if (timed_out) begin
                    bus_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: directed cases plus randomized
// transactions against a transaction-level model of the unit.
module tb_mem_interface;

    localparam int          TIMEOUT    = 4;
    localparam logic [31:0] RESET_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_mem = 1'b0;
    logic [1:0]  W_R_mem = 2'b00;
    logic [1:0]  wordsize_mem = 2'b00;
    logic        sign_mem = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy_mem, done_mem, aligned_mem, bus_err;
    logic [31:0] inst, rdata;

    mem_interface_if bus_if();

    mem_interface #(
        .TIMEOUT    (TIMEOUT),
        .RESET_INST (RESET_INST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en_mem       (en_mem),
        .W_R_mem      (W_R_mem),
        .wordsize_mem (wordsize_mem),
        .sign_mem     (sign_mem),
        .pc           (pc),
        .addr         (addr),
        .wdata        (wdata),
        .busy_mem     (busy_mem),
        .done_mem     (done_mem),
        .aligned_mem  (aligned_mem),
        .bus_err      (bus_err),
        .inst         (inst),
        .rdata        (rdata),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    // Expected outputs, maintained at transaction level by the driver.
    logic        exp_busy = 0, exp_done = 0, exp_valid = 0;
    logic        exp_aligned = 1, exp_bus_err = 0;
    logic [31:0] exp_inst = RESET_INST, exp_rdata = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0;
    logic [3:0]  exp_wstrb = 0;
    logic        exp_instr = 0, exp_store = 0;

    int          n_checks = 0, n_errors = 0;
    bit          chk_en = 0;
    int          done_cnt = 0, valid_cycles = 0;
    logic [31:0] last_addr = 0, last_wdata = 0;
    logic [3:0]  last_wstrb = 0;
    logic        last_instr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_mem", busy_mem, exp_busy);
            check("done_mem", done_mem, exp_done);
            check("mem_valid", bus_if.mem_valid, exp_valid);
            check("aligned_mem", aligned_mem, exp_aligned);
            check("bus_err", bus_err, exp_bus_err);
            check("inst", inst, exp_inst);
            check("rdata", rdata, exp_rdata);
            if (exp_valid) begin
                check("mem_addr", bus_if.mem_addr, exp_addr);
                check("mem_wstrb", bus_if.mem_wstrb, exp_wstrb);
                check("mem_instr", bus_if.mem_instr, exp_instr);
                if (exp_store) check("mem_wdata", bus_if.mem_wdata, exp_wdata);
            end
            if (done_mem) done_cnt++;
            if (bus_if.mem_valid) begin
                valid_cycles++;
                last_addr  = bus_if.mem_addr;
                last_wdata = bus_if.mem_wdata;
                last_wstrb = bus_if.mem_wstrb;
                last_instr = bus_if.mem_instr;
            end
        end
    end

    // Pick the addressed bytes out of the bus word and widen them to 32 bits.
    function automatic logic [31:0] extend_model(input logic [31:0] word, input int b,
                                                 input int nbytes, input bit sgn);
        logic [31:0] v;
        v = word >> (8 * b);
        if (nbytes == 1) begin
            v = v % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (nbytes == 2) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic model_reset();
        exp_busy = 0; exp_done = 0; exp_valid = 0;
        exp_aligned = 1; exp_bus_err = 0;
        exp_inst = RESET_INST; exp_rdata = 0;
    endtask

    // One request: lat is the REQ cycle index in which mem_ready is given.
    task automatic do_txn(input logic [1:0] wr, input logic [1:0] ws, input logic sg,
                          input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int lat);
        logic [31:0] ea;
        int          nbytes, b;
        bit          is_fetch, is_store, mis, fin;
        is_fetch = (wr == 2'b11);
        is_store = (wr == 2'b01);
        nbytes   = is_fetch ? 4 : (ws == 2'b00) ? 1 : (ws == 2'b01) ? 2 : 4;
        ea       = is_fetch ? p : a;
        b        = int'(ea % 4);
        mis      = (b % nbytes) != 0;

        W_R_mem = wr; wordsize_mem = ws; sign_mem = sg;
        pc = p; addr = a; wdata = wd; en_mem = 1'b1;
        @(posedge clk); #1;
        exp_aligned  = !mis;
        exp_bus_err  = 0;
        valid_cycles = 0;
        en_mem = 1'b0;
        W_R_mem = 2'($urandom); wordsize_mem = 2'($urandom); sign_mem = 1'($urandom);
        pc = $urandom; addr = $urandom; wdata = $urandom;
        if (mis) return;

        exp_busy  = 1; exp_valid = 1;
        exp_addr  = ea - b;
        exp_instr = is_fetch;
        exp_store = is_store;
        exp_wstrb = 0;
        exp_wdata = 0;
        if (is_store) begin
            for (int i = 0; i < 4; i++) begin
                exp_wstrb[i] = (i >= b) && (i < b + nbytes);
                exp_wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
            end
        end

        fin = 0;
        for (int c = 0; c < TIMEOUT && !fin; c++) begin
            en_mem = 1'($urandom);
            bus_if.mem_ready = (c == lat);
            bus_if.mem_rdata = (c == lat) ? rd : $urandom;
            @(posedge clk); #1;
            if (c == lat) begin
                fin = 1;
                if (is_fetch)       exp_inst  = rd;
                else if (!is_store) exp_rdata = extend_model(rd, b, nbytes, sg);
            end
        end
        if (!fin) exp_bus_err = 1;
        exp_valid = 0;
        exp_done  = 1;
        en_mem = 1'($urandom);
        bus_if.mem_ready = 1'($urandom);
        bus_if.mem_rdata = $urandom;
        @(posedge clk); #1;
        exp_done = 0; exp_busy = 0;
        en_mem = 1'b0;
        bus_if.mem_ready = 1'b0;
    endtask

    initial begin
        int d0;
        logic [31:0] m;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'h0;
        model_reset();
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Fetch, ready one cycle after valid.
        done_cnt = 0;
        do_txn(2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0050_0093, 1);
        check("fetch inst", inst, 32'h0050_0093);
        check("fetch addr", last_addr, 32'h100);
        check("fetch wstrb", last_wstrb, 4'b0000);
        check("fetch instr", last_instr, 1'b1);
        check("fetch valid cycles", valid_cycles, 2);
        check("fetch done pulses", done_cnt, 1);
        check("fetch aligned", aligned_mem, 1'b1);

        // Byte loads from the top lane, signed then unsigned.
        do_txn(2'b00, 2'b00, 1'b1, 32'h0, 32'h203, 32'h0, 32'h80FF_EE11, 0);
        check("lb addr", last_addr, 32'h200);
        check("lb rdata", rdata, 32'hFFFF_FF80);
        do_txn(2'b00, 2'b00, 1'b0, 32'h0, 32'h203, 32'h0, 32'h80FF_EE11, 2);
        check("lbu rdata", rdata, 32'h0000_0080);

        // Half store to the upper half.
        d0 = done_cnt;
        do_txn(2'b01, 2'b01, 1'b0, 32'h0, 32'h302, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
        check("sh addr", last_addr, 32'h300);
        check("sh wstrb", last_wstrb, 4'b1100);
        check("sh wdata", last_wdata, 32'hABCD_ABCD);
        check("sh done", done_cnt, d0 + 1);
        check("sh rdata kept", rdata, 32'h0000_0080);

        // Misaligned word load, then an aligned fetch.
        d0 = done_cnt;
        do_txn(2'b00, 2'b10, 1'b0, 32'h0, 32'h401, 32'h0, 32'h0, 0);
        @(posedge clk); #1;
        check("misaligned flag", aligned_mem, 1'b0);
        check("misaligned no valid", valid_cycles, 0);
        check("misaligned no done", done_cnt, d0);
        do_txn(2'b11, 2'b00, 1'b0, 32'h104, 32'h0, 32'h0, 32'h0000_0033, 0);
        check("realigned flag", aligned_mem, 1'b1);

        // Timeout: no mem_ready at all.
        d0 = done_cnt;
        do_txn(2'b11, 2'b00, 1'b0, 32'h108, 32'h0, 32'h0, 32'hFFFF_FFFF, 1000);
        check("timeout valid cycles", valid_cycles, TIMEOUT);
        check("timeout bus_err", bus_err, 1'b1);
        check("timeout done", done_cnt, d0 + 1);
        check("timeout inst kept", inst, 32'h0000_0033);

        // Reset while the request is outstanding.
        chk_en = 0;
        W_R_mem = 2'b11; pc = 32'h200; en_mem = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset valid", bus_if.mem_valid, 1'b1);
        check("pre-reset busy", busy_mem, 1'b1);
        reset = 1'b1;
        #1;
        check("async reset valid", bus_if.mem_valid, 1'b0);
        check("async reset busy", busy_mem, 1'b0);
        check("async reset inst", inst, RESET_INST);
        check("async reset bus_err", bus_err, 1'b0);
        @(posedge clk); #1;
        en_mem = 1'b0;
        reset  = 1'b0;
        model_reset();
        chk_en = 1;
        @(posedge clk); #1;

        // Randomized traffic; en_mem is also toggled while busy inside do_txn.
        for (int n = 0; n < 300; n++) begin
            m = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
            do_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom),
                   $urandom & m, $urandom & m, $urandom, $urandom,
                   $urandom_range(0, TIMEOUT + 1));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
